// File: rtl/dyn_display_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dyn_display_scanner
// Description : Parametrised 7-segment dynamic-display scanner with per-slot
//               anti-ghost blanking, PWM brightness, per-digit enable and a
//               tear-free frame-boundary shadow-update handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dyn_display_scanner #(
    parameter int NUM_DIGITS      = 4,
    parameter int SEG_WIDTH       = 8,
    parameter int SCAN_COUNT      = 50000,
    parameter int BLANK_CYCLES    = 16,
    parameter int BRIGHT_WIDTH    = 4,
    parameter int GATE_ACTIVE_LOW = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_DIGITS*SEG_WIDTH-1:0]  segIn,
    input  logic [NUM_DIGITS-1:0]            digitEn,
    input  logic [BRIGHT_WIDTH-1:0]          brightness,
    input  logic                             updReq,
    output logic                             updAck,
    output logic [SEG_WIDTH-1:0]             segOut,
    output logic [NUM_DIGITS-1:0]            gateOut,
    output logic                             frameTick,
    output logic [$clog2(NUM_DIGITS)-1:0]    curDigit
);

    localparam int c_CNT_W = $clog2(SCAN_COUNT);
    localparam int c_DIG_W = $clog2(NUM_DIGITS);
    localparam int c_PWM_W = (c_CNT_W > BRIGHT_WIDTH) ? c_CNT_W : BRIGHT_WIDTH;

    localparam logic [c_CNT_W-1:0]    c_SLOT_LAST = c_CNT_W'(SCAN_COUNT - 1);
    localparam logic [c_CNT_W-1:0]    c_BLANK     = c_CNT_W'(BLANK_CYCLES);
    localparam logic [c_DIG_W-1:0]    c_DIG_LAST  = c_DIG_W'(NUM_DIGITS - 1);
    localparam logic [c_PWM_W-1:0]    c_PWM_OFS   = c_PWM_W'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] c_ONE_HOT0  = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] c_GATE_OFF  =
        (GATE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [c_CNT_W-1:0]                         r_slotCnt;
    logic [c_DIG_W-1:0]                         r_digitIdx;
    logic [NUM_DIGITS-1:0][SEG_WIDTH-1:0]       r_shSeg;
    logic [NUM_DIGITS-1:0]                      r_shEn;
    logic [BRIGHT_WIDTH-1:0]                    r_shBright;

    logic                                       w_slotLast;
    logic                                       w_digitLast;
    logic                                       w_frameEnd;
    logic                                       w_phaseOn;
    logic [c_PWM_W-1:0]                         w_pwmDiff;
    logic [BRIGHT_WIDTH-1:0]                    w_pwm;
    logic                                       w_gateOn;
    logic [NUM_DIGITS-1:0]                      w_gateNext;
    logic [SEG_WIDTH-1:0]                       w_segNext;

    assign w_slotLast  = (r_slotCnt == c_SLOT_LAST);
    assign w_digitLast = (r_digitIdx == c_DIG_LAST);
    assign w_frameEnd  = w_slotLast && w_digitLast;

    // Slot / digit counters: a disabled digit still consumes its full slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slotCnt  <= '0;
            r_digitIdx <= '0;
        end else if (w_slotLast) begin
            r_slotCnt  <= '0;
            r_digitIdx <= w_digitLast ? '0 : r_digitIdx + c_DIG_W'(1);
        end else begin
            r_slotCnt  <= r_slotCnt + c_CNT_W'(1);
        end
    end

    // Shadow registers only ever change on the frame boundary (tear-free).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shSeg    <= '0;
            r_shEn     <= '0;
            r_shBright <= '0;
        end else if (w_frameEnd && updReq) begin
            r_shSeg    <= segIn;
            r_shEn     <= digitEn;
            r_shBright <= brightness;
        end
    end

    // The PWM difference is only consumed when the ON phase gates it, so the
    // wrap of the subtraction during BLANK is never observed.
    assign w_phaseOn = (r_slotCnt >= c_BLANK);
    assign w_pwmDiff = c_PWM_W'(r_slotCnt) - c_PWM_OFS;
    assign w_pwm     = w_pwmDiff[BRIGHT_WIDTH-1:0];

    assign w_gateOn   = w_phaseOn && r_shEn[r_digitIdx] && (w_pwm < r_shBright);
    assign w_gateNext = w_gateOn ? (c_ONE_HOT0 << r_digitIdx) : '0;
    assign w_segNext  = w_gateOn ? r_shSeg[r_digitIdx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            segOut    <= '0;
            gateOut   <= c_GATE_OFF;
            frameTick <= 1'b0;
            updAck    <= 1'b0;
            curDigit  <= '0;
        end else begin
            segOut    <= w_segNext;
            gateOut   <= w_gateNext ^ c_GATE_OFF;
            frameTick <= w_frameEnd;
            updAck    <= w_frameEnd && updReq;
            curDigit  <= r_digitIdx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dyn_display_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dyn_display_scanner
// Description : Randomised scoreboard bench for dyn_display_scanner against a
//               time-indexed behavioural model of the scanning rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dyn_display_scanner;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int S  = 8;
    localparam int B  = 2;
    localparam int BW = 2;
    localparam int FR = N * S;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*SW-1:0] segIn = '0;
    logic [N-1:0]    digitEn = '0;
    logic [BW-1:0]   brightness = '0;
    logic            updReq = 1'b0;
    logic            updAck;
    logic [SW-1:0]   segOut;
    logic [N-1:0]    gateOut;
    logic            frameTick;
    logic [1:0]      curDigit;

    dyn_display_scanner #(
        .NUM_DIGITS     (N),
        .SEG_WIDTH      (SW),
        .SCAN_COUNT     (S),
        .BLANK_CYCLES   (B),
        .BRIGHT_WIDTH   (BW),
        .GATE_ACTIVE_LOW(1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .segIn     (segIn),
        .digitEn   (digitEn),
        .brightness(brightness),
        .updReq    (updReq),
        .updAck    (updAck),
        .segOut    (segOut),
        .gateOut   (gateOut),
        .frameTick (frameTick),
        .curDigit  (curDigit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] seg;
        logic [N-1:0]  gate;
        logic          tick;
        logic          ack;
        logic [1:0]    cur;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   ack_cnt = 0;

    // Model state: m_c is the number of cycles since reset release.
    int            m_c = 0;
    logic [SW-1:0] m_seg [N];
    logic [N-1:0]  m_en = '0;
    int            m_bright = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h required %0h", nm, $time, got, exp);
        end
    endtask

    // Reference model: outputs follow from the cycle count since reset.
    initial begin
        exp_t e;
        int   off, dig, pwm;
        bit   g;
        for (int i = 0; i < N; i++) m_seg[i] = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_c = 0;
                for (int i = 0; i < N; i++) m_seg[i] = '0;
                m_en     = '0;
                m_bright = 0;
                sb.delete();
            end else begin
                off    = m_c % S;
                dig    = (m_c / S) % N;
                pwm    = (off >= B) ? ((off - B) % (1 << BW)) : 0;
                g      = (off >= B) && m_en[dig] && (pwm < m_bright);
                e.seg  = g ? m_seg[dig] : '0;
                e.gate = g ? ~(4'b0001 << dig) : 4'hF;
                e.tick = ((m_c % FR) == FR - 1);
                e.ack  = e.tick && updReq;
                e.cur  = 2'(dig);
                sb.push_back(e);
                if (e.ack) begin
                    for (int i = 0; i < N; i++) m_seg[i] = segIn[i*SW +: SW];
                    m_en     = digitEn;
                    m_bright = int'(brightness);
                end
                m_c++;
            end
        end
    end

    // Monitor: compare every presented output cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
            end else begin
                e.seg = '0; e.gate = 4'hF; e.tick = 1'b0; e.ack = 1'b0; e.cur = '0;
            end
            chk("segOut",    segOut,    e.seg);
            chk("gateOut",   gateOut,   e.gate);
            chk("frameTick", frameTick, e.tick);
            chk("updAck",    updAck,    e.ack);
            chk("curDigit",  curDigit,  e.cur);
            chk("gate_onehot", 32'($countones(~gateOut) <= 1), 1);
            if (updAck) ack_cnt++;
        end
    end

    task automatic wait_ack(input int exp_n, input int bound);
        int n = 0;
        bit got = 0;
        while (n < bound && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            #1;
            got = updAck;
        end
        chk("ack_seen", got, 1);
        if (exp_n > 0) chk("ack_latency", n, exp_n);
    endtask

    task automatic req_update(input logic [31:0] s, input logic [3:0] en, input logic [1:0] br);
        segIn = s; digitEn = en; brightness = br; updReq = 1'b1;
        wait_ack(-1, 80);
        updReq = 1'b0;
    endtask

    task automatic count_frame(output int gated, output int n11, output int n44,
                               output logic [3:0] seen);
        gated = 0; n11 = 0; n44 = 0; seen = '0;
        repeat (FR) begin
            @(negedge clk);
            #1;
            if (gateOut != 4'hF) gated++;
            if (gateOut == 4'b1110 && segOut == 8'h11) n11++;
            if (segOut == 8'h44) n44++;
            seen = seen | ~gateOut;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got timeout required finish", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, a, b, a0;
        logic [3:0] seen;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // First load: ack exactly one frame after release.
        segIn = 32'h44332211; digitEn = 4'hF; brightness = 2'd3; updReq = 1'b1;
        wait_ack(32, 80);
        updReq = 1'b0;
        count_frame(g, a, b, seen);
        chk("d0_lit_cycles", a, 5);
        chk("d3_0x44_cycles", b, 5);
        chk("gated_total", g, 20);

        // Zero brightness keeps every gate off.
        req_update($urandom, 4'hF, 2'd0);
        count_frame(g, a, b, seen);
        chk("bright0_gated", g, 0);

        // Digits 1 and 3 disabled.
        req_update($urandom, 4'b0101, 2'd3);
        count_frame(g, a, b, seen);
        chk("en0101_seen", seen, 4'b0101);

        // Inputs churn with no request: nothing loads.
        a0 = ack_cnt;
        repeat (3 * FR) begin
            @(negedge clk);
            segIn = $urandom; digitEn = 4'($urandom); brightness = 2'($urandom);
        end
        #1;
        chk("idle_no_ack", ack_cnt, a0);

        // Short request pulse that drops before the frame end.
        do @(negedge clk); while ((m_c % FR) != 20);
        updReq = 1'b1;
        repeat (3) @(negedge clk);
        updReq = 1'b0;
        repeat (FR) @(negedge clk);
        #1;
        chk("pulse_no_ack", ack_cnt, a0);

        // Random updates from arbitrary frame positions.
        for (int k = 0; k < 6; k++) begin
            req_update($urandom, 4'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        // Request held across frames: one ack per frame.
        segIn = $urandom; digitEn = 4'hF; brightness = 2'd2; updReq = 1'b1;
        wait_ack(-1, 80);
        a0 = ack_cnt;
        for (int k = 0; k < 3 * FR; k++) begin
            @(negedge clk);
            if (k % 7 == 0) segIn = $urandom;
        end
        #1;
        chk("held_acks", ack_cnt - a0, 3);

        // Asynchronous reset at frame cycle 13 with a pending request.
        do @(negedge clk); while ((m_c % FR) != 13);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_segOut",    segOut,    0);
        chk("rst_gateOut",   gateOut,   4'hF);
        chk("rst_frameTick", frameTick, 0);
        chk("rst_updAck",    updAck,    0);
        chk("rst_curDigit",  curDigit,  0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_ack(32, 80);
        updReq = 1'b0;

        // Ten frames of random traffic.
        for (int k = 0; k < 10 * FR; k++) begin
            @(negedge clk);
            segIn = $urandom; digitEn = 4'($urandom); brightness = 2'($urandom);
            updReq = ($urandom_range(0, 3) == 0);
        end
        updReq = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
